fetch_unit: RTL and testbench

- Program-counter and instruction-fetch stage that sits directly upstream of ProgramMemory.
- Drives the 8-bit fetch address into ProgramMemory and tracks the word in flight through the memory's one-cycle registered read.
- Hands each instruction, with its PC and a valid flag, to the decode stage.
- Supports start/halt control, decode-side stall (memory replay) and execute-side redirect (branch/jump) with flush.

---
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Program-counter and fetch stage in front of a one-cycle registered program memory.
// Tracks the word in flight through the memory and hands {instruction, pc, valid} to decode.
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               halt,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic [ADDR_W-1:0]  mem_address,
    input  logic [INSTR_W-1:0] mem_instruction,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    output logic               running
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               inflight_valid_q, inflight_valid_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic [INSTR_W-1:0] instr_out_q, instr_out_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               instr_valid_q, instr_valid_d;
    logic               running_q, running_d;
    logic               fetch;

    // While decode is stalled the memory re-reads the word it has not yet handed over.
    assign mem_address = (stall && inflight_valid_q) ? inflight_pc_q : pc_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (halt)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        running_d = (state_d == RUN);
    end

    always_comb begin
        pc_d             = pc_q;
        inflight_valid_d = inflight_valid_q;
        inflight_pc_d    = inflight_pc_q;
        instr_out_d      = instr_out_q;
        instr_pc_d       = instr_pc_q;
        instr_valid_d    = instr_valid_q;
        fetch            = (state_q == RUN) && !halt;

        if (redirect) begin
            pc_d             = redirect_target;
            inflight_valid_d = 1'b0;
            instr_valid_d    = 1'b0;
        end else if (!stall) begin
            if (fetch) begin
                pc_d             = pc_q + ADDR_W'(1);
                inflight_pc_d    = pc_q;
                inflight_valid_d = 1'b1;
            end else begin
                inflight_valid_d = 1'b0;
            end
            // Drain the in-flight word even when no new fetch is issued; the memory
            // output is meaningless unless a fetch was actually in flight.
            instr_valid_d = inflight_valid_q;
            if (inflight_valid_q) begin
                instr_out_d = mem_instruction;
                instr_pc_d  = inflight_pc_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            pc_q             <= RESET_PC;
            inflight_valid_q <= 1'b0;
            inflight_pc_q    <= '0;
            instr_out_q      <= '0;
            instr_pc_q       <= '0;
            instr_valid_q    <= 1'b0;
            running_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            inflight_valid_q <= inflight_valid_d;
            inflight_pc_q    <= inflight_pc_d;
            instr_out_q      <= instr_out_d;
            instr_pc_q       <= instr_pc_d;
            instr_valid_q    <= instr_valid_d;
            running_q        <= running_d;
        end
    end

    assign instr_out   = instr_out_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign running     = running_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with a behavioural one-cycle program memory.
// Memory word at address a is {a[3:0], a[3:0]}, so addresses 0..3 hold 00,11,22,33.
module tb_fetch_unit;

    logic       clk;
    logic       reset;
    logic       start, halt, stall, redirect;
    logic [7:0] redirect_target;
    logic [7:0] mem_address;
    logic [7:0] mem_instruction;
    logic [7:0] instr_out;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       running;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit #(
        .ADDR_W   (8),
        .INSTR_W  (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .halt            (halt),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .mem_address     (mem_address),
        .mem_instruction (mem_instruction),
        .instr_out       (instr_out),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .running         (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) mem_instruction <= {mem_address[3:0], mem_address[3:0]};

    // ctrl = {start, halt, stall, redirect}; addr is checked before the edge,
    // the remaining expectations after it.
    typedef struct {
        logic [3:0] ctrl;
        logic [7:0] tgt;
        logic [7:0] exp_addr;
        logic       exp_valid;
        logic [7:0] exp_pc;
        logic [7:0] exp_instr;
        logic       exp_run;
    } vec_t;

    vec_t vecs[37];

    function automatic vec_t mk(input logic [3:0] ctrl, input logic [7:0] tgt,
                                input logic [7:0] addr, input logic v,
                                input logic [7:0] pc, input logic [7:0] ins,
                                input logic run);
        vec_t r;
        r.ctrl      = ctrl;
        r.tgt       = tgt;
        r.exp_addr  = addr;
        r.exp_valid = v;
        r.exp_pc    = pc;
        r.exp_instr = ins;
        r.exp_run   = run;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_row(input vec_t v, input string tag);
        {start, halt, stall, redirect} = v.ctrl;
        redirect_target = v.tgt;
        #1;
        chk({tag, " mem_address"}, 32'(mem_address), 32'(v.exp_addr));
        @(posedge clk);
        #1;
        chk({tag, " instr_valid"}, 32'(instr_valid), 32'(v.exp_valid));
        chk({tag, " running"}, 32'(running), 32'(v.exp_run));
        if (v.exp_valid) begin
            chk({tag, " instr_pc"}, 32'(instr_pc), 32'(v.exp_pc));
            chk({tag, " instr_out"}, 32'(instr_out), 32'(v.exp_instr));
        end
        $display("%s ctrl=%b tgt=%02h addr=%02h -> valid=%0d pc=%02h instr=%02h run=%0d",
                 tag, v.ctrl, v.tgt, mem_address, instr_valid, instr_pc, instr_out, running);
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " instr_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, " instr_out"}, 32'(instr_out), 32'd0);
        chk({tag, " instr_pc"}, 32'(instr_pc), 32'd0);
        chk({tag, " running"}, 32'(running), 32'd0);
        chk({tag, " mem_address"}, 32'(mem_address), 32'd0);
    endtask

    initial begin
        // start, stream, 3-cycle stall
        vecs[0]  = mk(4'b1000, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
        vecs[1]  = mk(4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
        vecs[2]  = mk(4'b0000, 8'h00, 8'h01, 1'b1, 8'h00, 8'h00, 1'b1);
        vecs[3]  = mk(4'b0000, 8'h00, 8'h02, 1'b1, 8'h01, 8'h11, 1'b1);
        vecs[4]  = mk(4'b0010, 8'h00, 8'h02, 1'b1, 8'h01, 8'h11, 1'b1);
        vecs[5]  = mk(4'b0010, 8'h00, 8'h02, 1'b1, 8'h01, 8'h11, 1'b1);
        vecs[6]  = mk(4'b0010, 8'h00, 8'h02, 1'b1, 8'h01, 8'h11, 1'b1);
        vecs[7]  = mk(4'b0000, 8'h00, 8'h03, 1'b1, 8'h02, 8'h22, 1'b1);
        vecs[8]  = mk(4'b0000, 8'h00, 8'h04, 1'b1, 8'h03, 8'h33, 1'b1);
        // redirect back to 0, then redirect+stall to 2 while (0,00) is out
        vecs[9]  = mk(4'b0001, 8'h00, 8'h05, 1'b0, 8'h00, 8'h00, 1'b1);
        vecs[10] = mk(4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
        vecs[11] = mk(4'b0000, 8'h00, 8'h01, 1'b1, 8'h00, 8'h00, 1'b1);
        vecs[12] = mk(4'b0011, 8'h02, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1);
        vecs[13] = mk(4'b0000, 8'h00, 8'h02, 1'b0, 8'h00, 8'h00, 1'b1);
        vecs[14] = mk(4'b0000, 8'h00, 8'h03, 1'b1, 8'h02, 8'h22, 1'b1);
        vecs[15] = mk(4'b0000, 8'h00, 8'h04, 1'b1, 8'h03, 8'h33, 1'b1);
        // halt at pc_q=3 with (1,11) out, drain, restart
        vecs[16] = mk(4'b0001, 8'h01, 8'h05, 1'b0, 8'h00, 8'h00, 1'b1);
        vecs[17] = mk(4'b0000, 8'h00, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1);
        vecs[18] = mk(4'b0000, 8'h00, 8'h02, 1'b1, 8'h01, 8'h11, 1'b1);
        vecs[19] = mk(4'b0100, 8'h00, 8'h03, 1'b1, 8'h02, 8'h22, 1'b0);
        vecs[20] = mk(4'b0000, 8'h00, 8'h03, 1'b0, 8'h00, 8'h00, 1'b0);
        vecs[21] = mk(4'b0000, 8'h00, 8'h03, 1'b0, 8'h00, 8'h00, 1'b0);
        vecs[22] = mk(4'b1000, 8'h00, 8'h03, 1'b0, 8'h00, 8'h00, 1'b1);
        vecs[23] = mk(4'b0000, 8'h00, 8'h03, 1'b0, 8'h00, 8'h00, 1'b1);
        vecs[24] = mk(4'b0000, 8'h00, 8'h04, 1'b1, 8'h03, 8'h33, 1'b1);
        // wrap-around through FE, FF, 00, 01
        vecs[25] = mk(4'b0001, 8'hFE, 8'h05, 1'b0, 8'h00, 8'h00, 1'b1);
        vecs[26] = mk(4'b0000, 8'h00, 8'hFE, 1'b0, 8'h00, 8'h00, 1'b1);
        vecs[27] = mk(4'b0000, 8'h00, 8'hFF, 1'b1, 8'hFE, 8'hEE, 1'b1);
        vecs[28] = mk(4'b0000, 8'h00, 8'h00, 1'b1, 8'hFF, 8'hFF, 1'b1);
        vecs[29] = mk(4'b0000, 8'h00, 8'h01, 1'b1, 8'h00, 8'h00, 1'b1);
        vecs[30] = mk(4'b0000, 8'h00, 8'h02, 1'b1, 8'h01, 8'h11, 1'b1);
        // start in RUN ignored; start+halt in RUN halts; halt in IDLE ignored; start+halt in IDLE starts
        vecs[31] = mk(4'b1000, 8'h00, 8'h03, 1'b1, 8'h02, 8'h22, 1'b1);
        vecs[32] = mk(4'b1100, 8'h00, 8'h04, 1'b1, 8'h03, 8'h33, 1'b0);
        vecs[33] = mk(4'b0100, 8'h00, 8'h04, 1'b0, 8'h00, 8'h00, 1'b0);
        vecs[34] = mk(4'b1100, 8'h00, 8'h04, 1'b0, 8'h00, 8'h00, 1'b1);
        vecs[35] = mk(4'b0000, 8'h00, 8'h04, 1'b0, 8'h00, 8'h00, 1'b1);
        vecs[36] = mk(4'b0000, 8'h00, 8'h05, 1'b1, 8'h04, 8'h44, 1'b1);

        reset = 1'b1;
        {start, halt, stall, redirect} = 4'b0000;
        redirect_target = 8'h00;
        #2;
        chk_reset_state("por");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 37; i++) begin
            run_row(vecs[i], $sformatf("r%0d", i));
        end

        // Asynchronous reset between edges while a fetch is in flight.
        #2;
        reset = 1'b1;
        #1;
        chk_reset_state("async_rst");
        $display("async_rst valid=%0d pc=%02h instr=%02h run=%0d addr=%02h",
                 instr_valid, instr_pc, instr_out, running, mem_address);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_row(mk(4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0), $sformatf("post_rst%0d", i));
        end
        run_row(mk(4'b1000, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1), "restart0");
        run_row(mk(4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1), "restart1");
        run_row(mk(4'b0000, 8'h00, 8'h01, 1'b1, 8'h00, 8'h00, 1'b1), "restart2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
